// File: rtl/msg_block_buf_pkg.sv
// Shared BLAKE2s message-buffer geometry, FSM encodings and the byte-lane write payload.
// Imported by msg_block_buf and its word bank.
package msg_block_buf_pkg;

    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned WORD_CNT    = 16;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned IDX_W       = 6;
    localparam int unsigned WIDX_W      = 4;
    localparam int unsigned LANE_W      = 2;
    localparam int unsigned T_W         = 64;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic              en;
        logic [WIDX_W-1:0] word;
        logic [LANE_W-1:0] lane;
        logic [BYTE_W-1:0] data;
    } bank_wr_t;

    // t for a block going FULL: a first block restarts the count, a last block reports the message length
    function automatic logic [T_W-1:0] next_t(input logic           first,
                                              input logic           last,
                                              input logic [T_W-1:0] t_prev,
                                              input logic [T_W-1:0] ll);
        logic [T_W-1:0] base;
        base = first ? '0 : t_prev;
        return last ? ll : base + T_W'(BLOCK_BYTES);
    endfunction

endpackage

// File: rtl/msg_block_buf_word_bank.sv
// 16x32 message word register file: one byte-lane write port, clear-all, one async read port.
// Contents are deliberately not reset.
module msg_word_bank
    import msg_block_buf_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  bank_wr_t          wr,
    input  logic [WIDX_W-1:0] rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [WORD_CNT];

    // A write in the same cycle as a clear lands on top of the cleared word
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(WORD_CNT); i++) begin
                mem[i] <= '0;
            end
        end
        if (wr.en) begin
            mem[wr.word][{wr.lane, 3'b000} +: BYTE_W] <= wr.data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/msg_block_buf.sv
// BLAKE2s message block buffer: collects 64 bytes, presents the block with its t counter
// and first/last flags to the compression core, and flags protocol errors.
module msg_block_buf
    import msg_block_buf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              data_v_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic [IDX_W-1:0]  data_idx_i,
    input  logic              block_first_i,
    input  logic              block_last_i,
    input  logic [T_W-1:0]    ll_i,
    input  logic              blk_ack_i,
    input  logic [WIDX_W-1:0] m_idx_i,
    output logic              ready_o,
    output logic              blk_v_o,
    output logic [WORD_W-1:0] m_o,
    output logic [T_W-1:0]    t_o,
    output logic              first_o,
    output logic              last_o,
    output logic              err_o
);

    state_t            state_q;
    state_t            state_d;
    logic              ready_d;
    logic              blk_v_d;
    logic [IDX_W-1:0]  exp_q;
    logic              wr_fire;
    logic              go_full;
    logic              idx_bad;
    logic              drop;
    logic              bank_clr;
    bank_wr_t          bank_wr;

    assign wr_fire = (state_q == ST_FILL) && data_v_i;
    assign go_full = wr_fire && (data_idx_i == IDX_W'(BLOCK_BYTES - 1));
    assign idx_bad = wr_fire && (data_idx_i != exp_q);
    assign drop    = data_v_i && (state_q != ST_FILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL:  if (go_full)   state_d = ST_FULL;
            ST_FULL:  if (blk_ack_i) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_FILL;
            default:  state_d = ST_FILL;
        endcase
    end

    // Strobes decode the next state so their flops track state_q exactly
    always_comb begin
        ready_d = 1'b0;
        blk_v_d = 1'b0;
        case (state_d)
            ST_FILL: ready_d = 1'b1;
            ST_FULL: blk_v_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_o <= 1'b1;
            blk_v_o <= 1'b0;
        end else begin
            ready_o <= ready_d;
            blk_v_o <= blk_v_d;
        end
    end

    // Expected index, block header and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q   <= '0;
            t_o     <= '0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            if (wr_fire) begin
                exp_q <= go_full ? '0 : data_idx_i + IDX_W'(1);
            end
            if (go_full) begin
                first_o <= block_first_i;
                last_o  <= block_last_i;
                t_o     <= next_t(block_first_i, block_last_i, t_o, ll_i);
            end
            if (idx_bad || drop) begin
                err_o <= 1'b1;
            end
        end
    end

    // Byte 0 wipes the bank so a host-padded short block carries no stale words
    always_comb begin
        bank_wr  = '0;
        bank_clr = 1'b0;
        if (wr_fire) begin
            bank_wr.en   = 1'b1;
            bank_wr.word = data_idx_i[IDX_W-1:LANE_W];
            bank_wr.lane = data_idx_i[LANE_W-1:0];
            bank_wr.data = data_i;
            bank_clr     = (data_idx_i == '0);
        end
    end

    msg_word_bank u_bank (
        .clk     (clk),
        .clr     (bank_clr),
        .wr      (bank_wr),
        .rd_idx  (m_idx_i),
        .rd_data (m_o)
    );

endmodule

// File: tb/tb_msg_block_buf.sv
// Scoreboard bench for msg_block_buf: stimulus queues expected blocks, a monitor
// checks each presented block, acknowledges it and checks the drain latency.
module tb_msg_block_buf;

    typedef struct packed {
        logic [63:0]  t;
        logic         first;
        logic         last;
        logic [511:0] words;
        logic [7:0]   hold;
        logic         no_ack;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        data_v;
    logic [7:0]  data;
    logic [5:0]  data_idx;
    logic        bfirst;
    logic        blast;
    logic [63:0] ll;
    logic        ack;
    logic [3:0]  m_idx;
    logic        ready_o;
    logic        blk_v_o;
    logic [31:0] m_o;
    logic [63:0] t_o;
    logic        first_o;
    logic        last_o;
    logic        err_o;

    int   checks;
    int   errors;
    int   mon_done;
    logic [7:0] mb [64];
    exp_t sb [$];
    exp_t mon_e;
    bit   seen;

    msg_block_buf dut (
        .clk           (clk),
        .reset         (rst),
        .data_v_i      (data_v),
        .data_i        (data),
        .data_idx_i    (data_idx),
        .block_first_i (bfirst),
        .block_last_i  (blast),
        .ll_i          (ll),
        .blk_ack_i     (ack),
        .m_idx_i       (m_idx),
        .ready_o       (ready_o),
        .blk_v_o       (blk_v_o),
        .m_o           (m_o),
        .t_o           (t_o),
        .first_o       (first_o),
        .last_o        (last_o),
        .err_o         (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_words(input string name, input logic [511:0] words);
        for (int w = 0; w < 16; w++) begin
            m_idx = 4'(w);
            #1;
            chk($sformatf("%s[%0d]", name, w), 64'(m_o), 64'(words[32*w +: 32]));
        end
    endtask

    task automatic push_exp(input logic f, input logic l, input logic [63:0] t_exp,
                            input logic [7:0] hold, input logic no_ack);
        exp_t e;
        e.t      = t_exp;
        e.first  = f;
        e.last   = l;
        e.hold   = hold;
        e.no_ack = no_ack;
        e.words  = '0;
        for (int w = 0; w < 16; w++) begin
            e.words[32*w +: 32] = {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
        end
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [5:0] idx, input logic [7:0] d, input logic f, input logic l);
        @(negedge clk);
        data_v   = 1'b1;
        data_idx = idx;
        data     = d;
        bfirst   = f;
        blast    = l;
        @(posedge clk);
        #1;
        data_v = 1'b0;
    endtask

    task automatic send_tail(input int from, input logic f, input logic l);
        for (int i = from; i < 63; i++) begin
            send_byte(6'(i), mb[i], f, l);
        end
        chk("pre63_blk_v", 64'(blk_v_o), 64'd0);
        chk("pre63_ready", 64'(ready_o), 64'd1);
        send_byte(6'd63, mb[63], f, l);
        #1;
        chk("blk_v_latency", 64'(blk_v_o), 64'd1);
    endtask

    task automatic send_block(input logic f, input logic l, input logic [63:0] t_exp,
                              input logic [7:0] hold, input logic no_ack);
        push_exp(f, l, t_exp, hold, no_ack);
        send_tail(0, f, l);
    endtask

    task automatic wait_mon(input int target);
        for (int i = 0; i < 300 && mon_done < target; i++) begin
            @(posedge clk);
        end
        checks++;
        if (mon_done < target) begin
            errors++;
            $display("FAIL mon_timeout: got %0d blocks, expected %0d", mon_done, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_blk_v", 64'(blk_v_o), 64'd0);
        chk("rst_err",   64'(err_o),   64'd0);
        chk("rst_t",     t_o,          64'd0);
        chk("rst_first", 64'(first_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: checks each presented block, optionally holds, then acknowledges
    initial begin
        seen  = 1'b0;
        ack   = 1'b0;
        m_idx = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!blk_v_o) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got blk_v_o=1, expected none queued");
                end else begin
                    mon_e = sb.pop_front();
                    chk("t_o",     t_o,          mon_e.t);
                    chk("first_o", 64'(first_o), 64'(mon_e.first));
                    chk("last_o",  64'(last_o),  64'(mon_e.last));
                    check_words("m_o", mon_e.words);
                    if (mon_e.hold != 0) begin
                        repeat (int'(mon_e.hold)) @(posedge clk);
                        #2;
                        check_words("m_o_held", mon_e.words);
                        chk("t_o_held", t_o, mon_e.t);
                    end
                    if (!mon_e.no_ack) begin
                        ack = 1'b1;
                        @(posedge clk);
                        #2;
                        ack = 1'b0;
                        chk("drain_ready", 64'(ready_o), 64'd0);
                        chk("drain_blk_v", 64'(blk_v_o), 64'd0);
                        @(posedge clk);
                        #2;
                        chk("ack_ready", 64'(ready_o), 64'd1);
                        seen = 1'b0;
                    end
                    mon_done++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        mon_done = 0;
        rst      = 1'b0;
        data_v   = 1'b0;
        data     = '0;
        data_idx = '0;
        bfirst   = 1'b0;
        blast    = 1'b0;
        ll       = '0;
        #1;
        rst = 1'b1;
        #2;
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_blk_v", 64'(blk_v_o), 64'd0);
        chk("reset_t",     t_o,          64'd0);
        chk("reset_first", 64'(first_o), 64'd0);
        chk("reset_last",  64'(last_o),  64'd0);
        chk("reset_err",   64'(err_o),   64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single block 0x00..0x3F: word0 = 0x03020100, word15 = 0x3F3E3D3C
        ll = 64'd64;
        for (int i = 0; i < 64; i++) mb[i] = 8'(i);
        send_block(1'b1, 1'b1, 64'd64, 8'd0, 1'b0);
        wait_mon(1);
        chk("single_err", 64'(err_o), 64'd0);

        // Two-block message of 100 bytes
        ll = 64'd100;
        for (int i = 0; i < 64; i++) mb[i] = 8'(8'h80 + i);
        send_block(1'b1, 1'b0, 64'd64, 8'd0, 1'b0);
        wait_mon(2);
        for (int i = 0; i < 64; i++) mb[i] = (i < 36) ? 8'(8'h40 + i) : 8'h00;
        send_block(1'b0, 1'b1, 64'd100, 8'd0, 1'b0);
        wait_mon(3);
        chk("two_block_err", 64'(err_o), 64'd0);

        // Overflow byte while FULL is dropped and flags an error
        ll = 64'd64;
        for (int i = 0; i < 64; i++) mb[i] = 8'(255 - i);
        send_block(1'b1, 1'b1, 64'd64, 8'd3, 1'b0);
        send_byte(6'd5, 8'hEE, 1'b1, 1'b1);
        chk("overflow_err", 64'(err_o), 64'd1);
        wait_mon(4);
        chk("overflow_err_sticky", 64'(err_o), 64'd1);
        do_reset();

        // Index skip 0,1,3: error on idx 3, byte 2 reads back as cleared
        for (int i = 0; i < 64; i++) mb[i] = 8'(8'hA0 + i);
        mb[2] = 8'h00;
        push_exp(1'b1, 1'b1, 64'd64, 8'd0, 1'b0);
        send_byte(6'd0, mb[0], 1'b1, 1'b1);
        send_byte(6'd1, mb[1], 1'b1, 1'b1);
        chk("skip_err_before", 64'(err_o), 64'd0);
        send_byte(6'd3, mb[3], 1'b1, 1'b1);
        chk("skip_err", 64'(err_o), 64'd1);
        send_tail(4, 1'b1, 1'b1);
        wait_mon(5);
        do_reset();

        // Reset mid-fill at byte 30, then reset while FULL
        for (int i = 0; i < 30; i++) send_byte(6'(i), 8'(8'h11 + i), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 64; i++) mb[i] = 8'(8'h55 ^ i);
        send_block(1'b1, 1'b0, 64'd64, 8'd0, 1'b1);
        wait_mon(6);
        do_reset();
        for (int i = 0; i < 64; i++) mb[i] = 8'(8'hC0 ^ i);
        send_block(1'b1, 1'b0, 64'd64, 8'd0, 1'b0);
        wait_mon(7);

        // t wraps: preload 2^64-64, next non-last block reports 0
        ll = 64'hFFFF_FFFF_FFFF_FFC0;
        for (int i = 0; i < 64; i++) mb[i] = 8'(i * 3);
        send_block(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 8'd0, 1'b0);
        wait_mon(8);
        for (int i = 0; i < 64; i++) mb[i] = 8'(8'h5A ^ i);
        send_block(1'b0, 1'b0, 64'd0, 8'd0, 1'b0);
        wait_mon(9);
        chk("final_err", 64'(err_o), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
